// File: rtl/rand_frame_checker.sv
// Frame checker for a xorshift32 random source: gathers 256-sample frames, verifies the
// sample-to-sample chain and reports XOR, maximum, mismatch count and partial-frame timeouts.
module rand_frame_checker (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] rand_num,
   output logic        out_valid,
   output logic [31:0] frame_xor,
   output logic [31:0] frame_max,
   output logic [7:0]  err_cnt,
   output logic        timeout,
   output logic [15:0] frame_cnt,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_REPORT  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic [31:0] r_acc_xor;
   logic [31:0] r_acc_max;
   logic [31:0] r_pred;
   logic [7:0]  r_acc_err;
   logic [7:0]  r_smp_cnt;
   logic [9:0]  r_idle_cnt;

   logic [31:0] r_rep_xor;
   logic [31:0] r_rep_max;
   logic [7:0]  r_rep_err;
   logic        r_rep_timeout;
   logic [15:0] r_frame_cnt;

   logic        w_start;
   logic        w_accept;
   logic        w_done_full;
   logic        w_done_timeout;
   logic        w_mismatch;
   logic [31:0] w_xor_new;
   logic [31:0] w_max_new;
   logic [7:0]  w_err_new;

   function automatic logic [31:0] prng(input logic [31:0] x);
      logic [31:0] y;
      y = x ^ (x << 13);
      y = y ^ (y >> 17);
      y = y ^ (y << 5);
      return y;
   endfunction

   // Accumulators including the sample on the bus, used for both update and final report.
   assign w_mismatch = (rand_num != r_pred);
   assign w_xor_new  = r_acc_xor ^ rand_num;
   assign w_max_new  = (rand_num > r_acc_max) ? rand_num : r_acc_max;
   assign w_err_new  = r_acc_err + {7'd0, w_mismatch};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_start        = 1'b0;
      w_accept       = 1'b0;
      w_done_full    = 1'b0;
      w_done_timeout = 1'b0;
      out_valid      = 1'b0;
      busy           = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_start      = 1'b1;
               w_state_next = S_COLLECT;
            end
         end
         S_COLLECT: begin
            busy = 1'b1;
            if (in_valid) begin
               w_accept = 1'b1;
               if (r_smp_cnt == 8'd255) begin
                  w_done_full  = 1'b1;
                  w_state_next = S_REPORT;
               end
            end else if (r_idle_cnt == 10'd1023) begin
               // This idle cycle is the 1024th in a row.
               w_done_timeout = 1'b1;
               w_state_next   = S_REPORT;
            end
         end
         S_REPORT: begin
            out_valid = 1'b1;
            if (in_valid) begin
               w_start      = 1'b1;
               w_state_next = S_COLLECT;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc_xor     <= 32'd0;
         r_acc_max     <= 32'd0;
         r_pred        <= 32'd0;
         r_acc_err     <= 8'd0;
         r_smp_cnt     <= 8'd0;
         r_idle_cnt    <= 10'd0;
         r_rep_xor     <= 32'd0;
         r_rep_max     <= 32'd0;
         r_rep_err     <= 8'd0;
         r_rep_timeout <= 1'b0;
         r_frame_cnt   <= 16'd0;
      end else begin
         if (w_start) begin
            r_acc_xor  <= rand_num;
            r_acc_max  <= rand_num;
            r_acc_err  <= 8'd0;
            r_smp_cnt  <= 8'd1;
            r_pred     <= prng(rand_num);
            r_idle_cnt <= 10'd0;
         end else if (w_accept) begin
            r_acc_xor  <= w_xor_new;
            r_acc_max  <= w_max_new;
            r_acc_err  <= w_err_new;
            r_smp_cnt  <= r_smp_cnt + 8'd1;
            r_pred     <= prng(rand_num);
            r_idle_cnt <= 10'd0;
         end else if (r_state == S_COLLECT) begin
            r_idle_cnt <= r_idle_cnt + 10'd1;
         end

         if (w_done_full) begin
            r_rep_xor     <= w_xor_new;
            r_rep_max     <= w_max_new;
            r_rep_err     <= w_err_new;
            r_rep_timeout <= 1'b0;
            r_frame_cnt   <= r_frame_cnt + 16'd1;
         end else if (w_done_timeout) begin
            r_rep_xor     <= r_acc_xor;
            r_rep_max     <= r_acc_max;
            r_rep_err     <= r_acc_err;
            r_rep_timeout <= 1'b1;
            r_frame_cnt   <= r_frame_cnt + 16'd1;
         end
      end
   end

   assign frame_xor = r_rep_xor;
   assign frame_max = r_rep_max;
   assign err_cnt   = r_rep_err;
   assign timeout   = r_rep_timeout;
   assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_rand_frame_checker.sv
// Randomized bench for rand_frame_checker: drives xorshift chains and compares each
// frame report against a queue-based reference model.
module tb_rand_frame_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] rand_num = 32'd0;
   logic        out_valid;
   logic [31:0] frame_xor;
   logic [31:0] frame_max;
   logic [7:0]  err_cnt;
   logic        timeout;
   logic [15:0] frame_cnt;
   logic        busy;

   rand_frame_checker dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .rand_num  (rand_num),
      .out_valid (out_valid),
      .frame_xor (frame_xor),
      .frame_max (frame_max),
      .err_cnt   (err_cnt),
      .timeout   (timeout),
      .frame_cnt (frame_cnt),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   int n_cmp = 0;
   int n_bad = 0;
   int last_edge = 0;

   typedef struct {
      logic [31:0] x;
      logic [31:0] m;
      logic [7:0]  e;
      logic        to;
      logic [15:0] fc;
      int          ed;
   } rep_t;

   rep_t        reps[$];
   logic [31:0] smp [0:1023];

   always @(negedge clk) begin : mon
      rep_t r;
      if (out_valid === 1'b1) begin
         r.x  = frame_xor;
         r.m  = frame_max;
         r.e  = err_cnt;
         r.to = timeout;
         r.fc = frame_cnt;
         r.ed = edge_cnt;
         reps.push_back(r);
         $display("report edge=%0d xor=%08h max=%08h err=%0d timeout=%0b frame_cnt=%0d",
                  r.ed, r.x, r.m, r.e, r.to, r.fc);
      end
   end

   function automatic logic [31:0] mprng(input logic [31:0] v);
      logic [31:0] t;
      t = v ^ (v << 13);
      t = t ^ (t >> 17);
      t = t ^ (t << 5);
      return t;
   endfunction

   function automatic rep_t get_rep(input int i);
      rep_t r;
      r = '{default: 0};
      if (i < reps.size()) r = reps[i];
      return r;
   endfunction

   // Reference: a frame is a list of samples; xor/max over the list, err = broken chain links.
   function automatic void model(input int s, input int n, output logic [31:0] x,
                                 output logic [31:0] m, output logic [7:0] e);
      x = 32'd0;
      m = 32'd0;
      e = 8'd0;
      for (int i = 0; i < n; i++) begin
         x = x ^ smp[s+i];
         if (smp[s+i] > m) m = smp[s+i];
         if (i > 0 && smp[s+i] != mprng(smp[s+i-1])) e = e + 8'd1;
      end
   endfunction

   task automatic chain(input int s, input int n, input logic [31:0] seed);
      smp[s] = seed;
      for (int i = 1; i < n; i++) smp[s+i] = mprng(smp[s+i-1]);
   endtask

   task automatic send(input logic [31:0] v);
      in_valid = 1'b1;
      rand_num = v;
      @(posedge clk);
      #1;
      last_edge = edge_cnt;
      in_valid  = 1'b0;
      rand_num  = $urandom;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      reps.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (frame_xor !== 32'd0) begin n_bad++; $display("FAIL rst_frame_xor: got %h want 0", frame_xor); end
      n_cmp++; if (frame_max !== 32'd0) begin n_bad++; $display("FAIL rst_frame_max: got %h want 0", frame_max); end
      n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); end
      n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL rst_timeout: got %b want 0", timeout); end
      n_cmp++; if (frame_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_frame_cnt: got %0d want 0", frame_cnt); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      rst = 1'b0;
      idle(2);
      send($urandom);
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_busy_after_sample: got %b want 1", busy); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_async_busy: got %b want 0", busy); end
      @(posedge clk);
      #1 rst = 1'b0;
      reps.delete();
   endtask

   task automatic test_clean_chain();
      logic [31:0] x, m;
      logic [7:0]  e;
      rep_t r;
      do_reset();
      chain(0, 256, 32'h0000_0001);
      for (int i = 0; i < 256; i++) begin
         send(smp[i]);
         if (i == 100) begin
            n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL clean_busy: got %b want 1", busy); end
         end
      end
      repeat (4) @(negedge clk);
      model(0, 256, x, m, e);
      r = get_rep(0);
      n_cmp++; if (reps.size() != 1) begin n_bad++; $display("FAIL clean_reports: got %0d want 1", reps.size()); end
      n_cmp++; if (r.ed - last_edge + 1 != 1) begin n_bad++; $display("FAIL clean_latency: got %0d want 1", r.ed - last_edge + 1); end
      n_cmp++; if (r.x !== x) begin n_bad++; $display("FAIL clean_xor: got %h want %h", r.x, x); end
      n_cmp++; if (r.m !== m) begin n_bad++; $display("FAIL clean_max: got %h want %h", r.m, m); end
      n_cmp++; if (r.e !== 8'd0) begin n_bad++; $display("FAIL clean_err: got %0d want 0", r.e); end
      n_cmp++; if (r.to !== 1'b0) begin n_bad++; $display("FAIL clean_timeout: got %b want 0", r.to); end
      n_cmp++; if (r.fc !== 16'd1) begin n_bad++; $display("FAIL clean_frame_cnt: got %0d want 1", r.fc); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL clean_busy_after: got %b want 0", busy); end
      n_cmp++; if (frame_xor !== x) begin n_bad++; $display("FAIL clean_xor_hold: got %h want %h", frame_xor, x); end
   endtask

   task automatic test_corruption();
      logic [31:0] x, m;
      logic [7:0]  e;
      rep_t r;
      do_reset();
      chain(0, 256, 32'h0000_0001);
      smp[9] = smp[9] ^ 32'h1;
      for (int i = 0; i < 256; i++) send(smp[i]);
      repeat (4) @(negedge clk);
      model(0, 256, x, m, e);
      r = get_rep(0);
      n_cmp++; if (reps.size() != 1) begin n_bad++; $display("FAIL corrupt_reports: got %0d want 1", reps.size()); end
      n_cmp++; if (r.e !== 8'd2) begin n_bad++; $display("FAIL corrupt_err: got %0d want 2", r.e); end
      n_cmp++; if (r.x !== x) begin n_bad++; $display("FAIL corrupt_xor: got %h want %h", r.x, x); end
      n_cmp++; if (r.m !== m) begin n_bad++; $display("FAIL corrupt_max: got %h want %h", r.m, m); end
      n_cmp++; if (r.to !== 1'b0) begin n_bad++; $display("FAIL corrupt_timeout: got %b want 0", r.to); end
   endtask

   task automatic test_gapped();
      logic [31:0] x, m;
      logic [7:0]  e;
      rep_t r;
      int g;
      do_reset();
      chain(0, 256, $urandom | 32'h1);
      for (int i = 0; i < 256; i++) begin
         if (i > 0) begin
            g = (i == 128) ? 1023 : ((i % 32 == 0) ? 1000 : int'($urandom_range(0, 3)));
            idle(g);
         end
         send(smp[i]);
      end
      repeat (4) @(negedge clk);
      model(0, 256, x, m, e);
      r = get_rep(0);
      n_cmp++; if (reps.size() != 1) begin n_bad++; $display("FAIL gap_reports: got %0d want 1", reps.size()); end
      n_cmp++; if (r.to !== 1'b0) begin n_bad++; $display("FAIL gap_timeout: got %b want 0", r.to); end
      n_cmp++; if (r.e !== 8'd0) begin n_bad++; $display("FAIL gap_err: got %0d want 0", r.e); end
      n_cmp++; if (r.x !== x) begin n_bad++; $display("FAIL gap_xor: got %h want %h", r.x, x); end
      n_cmp++; if (r.m !== m) begin n_bad++; $display("FAIL gap_max: got %h want %h", r.m, m); end
      n_cmp++; if (r.ed - last_edge + 1 != 1) begin n_bad++; $display("FAIL gap_latency: got %0d want 1", r.ed - last_edge + 1); end
   endtask

   task automatic test_timeout();
      logic [31:0] x, m;
      logic [7:0]  e;
      rep_t r;
      do_reset();
      chain(0, 100, $urandom);
      for (int i = 0; i < 100; i++) send(smp[i]);
      repeat (500) @(negedge clk);
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL to_busy_mid_gap: got %b want 1", busy); end
      for (int k = 0; k < 700 && reps.size() == 0; k++) @(negedge clk);
      repeat (3) @(negedge clk);
      model(0, 100, x, m, e);
      r = get_rep(0);
      n_cmp++; if (reps.size() != 1) begin n_bad++; $display("FAIL to_reports: got %0d want 1", reps.size()); end
      n_cmp++; if (r.ed - last_edge + 1 != 1025) begin n_bad++; $display("FAIL to_latency: got %0d want 1025", r.ed - last_edge + 1); end
      n_cmp++; if (r.to !== 1'b1) begin n_bad++; $display("FAIL to_timeout: got %b want 1", r.to); end
      n_cmp++; if (r.e !== 8'd0) begin n_bad++; $display("FAIL to_err: got %0d want 0", r.e); end
      n_cmp++; if (r.x !== x) begin n_bad++; $display("FAIL to_xor: got %h want %h", r.x, x); end
      n_cmp++; if (r.m !== m) begin n_bad++; $display("FAIL to_max: got %h want %h", r.m, m); end
      n_cmp++; if (r.fc !== 16'd1) begin n_bad++; $display("FAIL to_frame_cnt: got %0d want 1", r.fc); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL to_busy_after: got %b want 0", busy); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] x0, m0, x1, m1;
      logic [7:0]  e0, e1;
      rep_t r0, r1;
      do_reset();
      chain(0, 256, $urandom | 32'h1);
      chain(256, 256, $urandom | 32'h2);
      for (int i = 0; i < 512; i++) send(smp[i]);
      repeat (4) @(negedge clk);
      model(0, 256, x0, m0, e0);
      model(256, 256, x1, m1, e1);
      r0 = get_rep(0);
      r1 = get_rep(1);
      n_cmp++; if (reps.size() != 2) begin n_bad++; $display("FAIL b2b_reports: got %0d want 2", reps.size()); end
      n_cmp++; if (r0.e !== 8'd0) begin n_bad++; $display("FAIL b2b_err0: got %0d want 0", r0.e); end
      n_cmp++; if (r1.e !== 8'd0) begin n_bad++; $display("FAIL b2b_err1: got %0d want 0", r1.e); end
      n_cmp++; if (r0.x !== x0) begin n_bad++; $display("FAIL b2b_xor0: got %h want %h", r0.x, x0); end
      n_cmp++; if (r1.x !== x1) begin n_bad++; $display("FAIL b2b_xor1: got %h want %h", r1.x, x1); end
      n_cmp++; if (r0.m !== m0) begin n_bad++; $display("FAIL b2b_max0: got %h want %h", r0.m, m0); end
      n_cmp++; if (r1.m !== m1) begin n_bad++; $display("FAIL b2b_max1: got %h want %h", r1.m, m1); end
      n_cmp++; if (r0.fc !== 16'd1) begin n_bad++; $display("FAIL b2b_cnt0: got %0d want 1", r0.fc); end
      n_cmp++; if (r1.fc !== 16'd2) begin n_bad++; $display("FAIL b2b_cnt1: got %0d want 2", r1.fc); end
      n_cmp++; if (r0.ed - (last_edge - 256) + 1 != 1) begin n_bad++; $display("FAIL b2b_latency0: got %0d want 1", r0.ed - (last_edge - 256) + 1); end
      n_cmp++; if (r1.ed - last_edge + 1 != 1) begin n_bad++; $display("FAIL b2b_latency1: got %0d want 1", r1.ed - last_edge + 1); end
      n_cmp++; if (frame_cnt !== 16'd2) begin n_bad++; $display("FAIL b2b_frame_cnt: got %0d want 2", frame_cnt); end
   endtask

   task automatic test_random_frames();
      logic [31:0] x, m;
      logic [7:0]  e;
      rep_t r;
      int k;
      do_reset();
      for (int f = 0; f < 3; f++) begin
         chain(0, 256, $urandom);
         k = int'($urandom_range(0, 4));
         for (int c = 0; c < k; c++) smp[$urandom_range(0, 255)] ^= ($urandom | 32'h1);
         for (int i = 0; i < 256; i++) begin
            if (i > 0) idle(int'($urandom_range(0, 2)));
            send(smp[i]);
         end
         repeat (4) @(negedge clk);
         model(0, 256, x, m, e);
         r = get_rep(f);
         n_cmp++; if (r.e !== e) begin n_bad++; $display("FAIL rnd%0d_err: got %0d want %0d", f, r.e, e); end
         n_cmp++; if (r.x !== x) begin n_bad++; $display("FAIL rnd%0d_xor: got %h want %h", f, r.x, x); end
         n_cmp++; if (r.m !== m) begin n_bad++; $display("FAIL rnd%0d_max: got %h want %h", f, r.m, m); end
         n_cmp++; if (r.fc !== 16'(f + 1)) begin n_bad++; $display("FAIL rnd%0d_frame_cnt: got %0d want %0d", f, r.fc, f + 1); end
      end
      n_cmp++; if (reps.size() != 3) begin n_bad++; $display("FAIL rnd_reports: got %0d want 3", reps.size()); end
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] x, m;
      logic [7:0]  e;
      rep_t r;
      reps.delete();
      chain(0, 50, $urandom);
      for (int i = 0; i < 50; i++) send(smp[i]);
      n_cmp++; if (reps.size() != 0) begin n_bad++; $display("FAIL mid_early_report: got %0d want 0", reps.size()); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (frame_cnt !== 16'd0) begin n_bad++; $display("FAIL mid_rst_frame_cnt: got %0d want 0", frame_cnt); end
      n_cmp++; if (frame_xor !== 32'd0) begin n_bad++; $display("FAIL mid_rst_xor: got %h want 0", frame_xor); end
      n_cmp++; if (frame_max !== 32'd0) begin n_bad++; $display("FAIL mid_rst_max: got %h want 0", frame_max); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
      @(posedge clk);
      #1 rst = 1'b0;
      chain(0, 256, $urandom | 32'h1);
      for (int i = 0; i < 256; i++) send(smp[i]);
      repeat (4) @(negedge clk);
      model(0, 256, x, m, e);
      r = get_rep(0);
      n_cmp++; if (reps.size() != 1) begin n_bad++; $display("FAIL mid_reports: got %0d want 1", reps.size()); end
      n_cmp++; if (r.e !== 8'd0) begin n_bad++; $display("FAIL mid_err: got %0d want 0", r.e); end
      n_cmp++; if (r.fc !== 16'd1) begin n_bad++; $display("FAIL mid_frame_cnt: got %0d want 1", r.fc); end
      n_cmp++; if (r.x !== x) begin n_bad++; $display("FAIL mid_xor: got %h want %h", r.x, x); end
      n_cmp++; if (r.to !== 1'b0) begin n_bad++; $display("FAIL mid_timeout: got %b want 0", r.to); end
   endtask

   initial begin
      test_reset();
      test_clean_chain();
      test_corruption();
      test_gapped();
      test_timeout();
      test_back_to_back();
      test_random_frames();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rand_frame_checker.md
RAND_FRAME_CHECKER -- requirements
Module: rand_frame_checker

Interface
REQ-001 The block SHALL have port `clk`: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port `rst`: input, 1 bit, asynchronous active-high reset; assertion clears all state immediately, independent of `clk`.
REQ-003 The block SHALL have port `in_valid`: input, 1 bit; the random-number output stage marks a sample valid for exactly this cycle.
REQ-004 The block SHALL have port `rand_num`: input, 32 bits; the sample value, meaningful only when `in_valid`=1.
REQ-005 The block SHALL have port `out_valid`: output, 1 bit; one-cycle pulse carrying a frame report.
REQ-006 The block SHALL have port `frame_xor`: output, 32 bits; bitwise XOR of all accepted samples of the reported frame.
REQ-007 The block SHALL have port `frame_max`: output, 32 bits; largest unsigned sample of the reported frame.
REQ-008 The block SHALL have port `err_cnt`: output, 8 bits; number of chain mismatches in the reported frame.
REQ-009 The block SHALL have port `timeout`: output, 1 bit; valid with `out_valid`; 1 means the report is for a partial frame.
REQ-010 The block SHALL have port `frame_cnt`: output, 16 bits; count of reports issued since reset.
REQ-011 The block SHALL have port `busy`: output, 1 bit; 1 while a frame is being collected.

Function
REQ-012 A frame SHALL consist of exactly 256 accepted samples (`in_valid`=1).
- Gaps of any length ≤1023 cycles between samples SHALL be tolerated.
REQ-013 The FSM SHALL have three states: IDLE, COLLECT, REPORT.
- IDLE→COLLECT on `in_valid`.
- COLLECT→REPORT on acceptance of the 256th sample, or on timeout (REQ-019).
- REPORT→IDLE after one cycle; REPORT→COLLECT if `in_valid`=1 during REPORT.
REQ-014 The first sample of a frame SHALL:
- initialise the accumulators: xor=sample, max=sample, err=0, sample counter=1;
- not be chain-checked.
REQ-015 Each later sample S SHALL be compared against P' = prng(P), where P is the previously accepted sample of the same frame.
- prng(x): x ^= x<<13; x ^= x>>17; x ^= x<<5; all 32-bit, logical shifts, bits above 31 discarded.
- S≠P' SHALL increment err by 1.
- Maximum possible err is 255, which fits 8 bits; no saturation logic.
REQ-016 Each accepted sample SHALL be XORed into the xor accumulator, and SHALL replace max when unsigned-greater than max.
REQ-017 Report timing:
- In REPORT, `out_valid`=1 for exactly one cycle, with `frame_xor`, `frame_max`, `err_cnt` and `timeout` showing the completed frame.
- Report latency: one cycle after the edge accepting the 256th sample.
REQ-018 `frame_cnt` SHALL increment by 1 on every report and wrap from 0xFFFF to 0x0000.
- Report outputs SHALL hold their last values between reports.
REQ-019 Timeout:
- In COLLECT, an idle counter SHALL count consecutive cycles with `in_valid`=0 and clear on any accepted sample.
- On reaching 1024, the FSM SHALL go to REPORT with `timeout`=1, reporting the partial accumulators.
REQ-020 A sample with `in_valid`=1 in the REPORT cycle SHALL be accepted as sample 1 of the next frame (REQ-014) with no loss.
REQ-021 `busy` SHALL be 1 in COLLECT only.
- `in_valid` is ignored for nothing: every `in_valid`=1 cycle is accepted in every state.

Reset
REQ-022 During and after `rst`, the outputs SHALL be: `out_valid`=0, `frame_xor`=0, `frame_max`=0, `err_cnt`=0, `timeout`=0, `frame_cnt`=0, `busy`=0; the FSM SHALL be in IDLE and all counters 0.
REQ-023 `rst` asserted mid-frame SHALL discard the partial frame with no report.
- The first `in_valid` after release SHALL start a new frame.

Verification
REQ-024 Clean chain: 256 samples, seed 0x00000001 then successive prng values (2nd = 0x00042021), one per cycle.
- Expect a single `out_valid` pulse one cycle after the 256th sample.
- Expect `err_cnt`=0, `timeout`=0, `frame_cnt`=1, and `frame_xor`/`frame_max` matching the model.
REQ-025 Corruption: the same chain with sample 10 XOR 0x1.
- Expect `err_cnt`=2 (sample 10 and sample 11 mismatch).
REQ-026 Gapped input: the chain with 1000-cycle gaps between samples.
- Expect no timeout and the report as REQ-024.
REQ-027 Timeout: 100 chain samples then `in_valid` held low.
- Expect `out_valid`, `timeout`=1 and `err_cnt`=0, 1025 cycles after the 100th sample edge.
- Expect `frame_xor` equal to the XOR of the 100 samples.
REQ-028 Back-to-back frames: 512 consecutive samples with no gap, including a sample in the REPORT cycle.
- Expect two reports, `frame_cnt`=2, and both frames with `err_cnt`=0 (frame 2 seeded by sample 257).
REQ-029 Reset mid-frame: `rst` pulsed after 50 samples, then a 256-sample chain.
- Expect no report before the reset.
- Expect one report with `err_cnt`=0 and `frame_cnt`=1.
